spart_tx_sched: RTL and testbench



---
 rtl/spart_tx_sched.sv | 122 ++++++++++++
 tb/tb_spart_tx_sched.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/spart_tx_sched.sv
// spart_tx_sched: SPART transmit controller (baud tick, TX FIFO, load/busy sequencing); optional irq via SPART_TX_IRQ_EN
module spart_tx_sched #(
   parameter int          DEPTH     = 4,
   parameter logic [15:0] DIV_RESET = 16'd325
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       iocs,
   input  logic       iorw,
   input  logic [1:0] ioaddr,
   input  logic [7:0] bus_wdata,
   output logic [7:0] bus_rdata,
   output logic [7:0] tx_data,
   output logic       tx_start,
   output logic       tx_en,
`ifdef SPART_TX_IRQ_EN
   output logic       irq,
`endif
   input  logic       tx_tbr
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] ONE = 1;

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

   state_t      state;
   logic [7:0]  mem [DEPTH];
   logic [AW:0] wp, rp;
   logic [15:0] div, cnt, new_div;
   logic        ovr, wr, rd, push, pop, push_ok, empty, full, tbr_all, irq_bit;
   logic [7:0]  status;

   assign wr      = iocs & ~iorw;
   assign rd      = iocs & iorw;
   assign push    = wr && ioaddr == 2'b00;
   assign empty   = wp == rp;
   assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign pop     = state == IDLE && !empty && tx_tbr;
   assign push_ok = push && (!full || pop);
   assign tbr_all = empty && state == IDLE && tx_tbr;
   assign new_div = ioaddr[0] ? {bus_wdata, div[7:0]} : {div[15:8], bus_wdata};
   assign status  = {4'b0, irq_bit, ovr, full, tbr_all};

   // Combinational read mux; idle bus reads as zero
   always_comb
      bus_rdata = !rd              ? 8'h00 :
                  ioaddr == 2'b01  ? status :
                  ioaddr == 2'b10  ? div[7:0] :
                  ioaddr == 2'b11  ? div[15:8] : 8'h00;

   // Divisor register and free-running baud down counter; a divisor write restarts the count
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         div   <= DIV_RESET;
         cnt   <= DIV_RESET;
         tx_en <= 1'b0;
      end else if (wr && ioaddr[1]) begin
         div   <= new_div;
         cnt   <= new_div;
         tx_en <= 1'b0;
      end else begin
         tx_en <= cnt == 16'd0 && div != 16'd0;
         cnt   <= cnt == 16'd0 ? div : cnt - 16'd1;
      end

   // FIFO storage; a push into a full FIFO only lands when the head is popped on the same edge
   always_ff @(posedge clk)
      if (push_ok) mem[wp[AW-1:0]] <= bus_wdata;

   // FIFO pointers and sticky overrun flag; a dropped byte beats a status-read clear
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wp  <= '0;
         rp  <= '0;
         ovr <= 1'b0;
      end else begin
         if (push_ok) wp <= wp + ONE;
         if (pop) rp <= rp + ONE;
         ovr <= (push && !push_ok) ? 1'b1 : (rd && ioaddr == 2'b01) ? 1'b0 : ovr;
      end

   // Scheduler: pop one byte, strobe the load, then follow the transmitter busy/ready handshake
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state    <= IDLE;
         tx_start <= 1'b0;
         tx_data  <= 8'h00;
      end else begin
         unique case (state)
            IDLE:
               if (pop) begin
                  tx_data  <= mem[rp[AW-1:0]];
                  tx_start <= 1'b1;
                  state    <= LAUNCH;
               end
            LAUNCH: begin
               tx_start <= 1'b0;
               state    <= WAIT_BUSY;
            end
            WAIT_BUSY: if (!tx_tbr) state <= WAIT_DONE;
            WAIT_DONE: if (tx_tbr) state <= IDLE;
         endcase
      end

`ifdef SPART_TX_IRQ_EN
   logic irq_en;
   assign irq_bit = irq_en;

   // Interrupt enable register and registered ready interrupt
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         irq_en <= 1'b0;
         irq    <= 1'b0;
      end else begin
         if (wr && ioaddr == 2'b01) irq_en <= bus_wdata[3];
         irq <= tbr_all & irq_en;
      end
`else
   assign irq_bit = 1'b0;
`endif

endmodule

// File: tb/tb_spart_tx_sched.sv
// tb_spart_tx_sched: directed + randomized bench with transmitter model and byte scoreboard
module tb_spart_tx_sched;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst, iocs, iorw, tx_tbr, tx_start, tx_en;
   logic [1:0] ioaddr;
   logic [7:0] bus_wdata, bus_rdata, tx_data;
`ifdef SPART_TX_IRQ_EN
   logic       irq;
`endif

   int         checks = 0;
   int         errs = 0;
   logic [7:0] exp_q[$];
   bit         force_busy = 1'b0;
   bit         busy = 1'b0;
   bit         rose = 1'b1;
   int         busy_ticks = 2;
   int         busy_left = 0;
   int         busy_cyc = 0;
   int         n_starts = 0;

   always #5 clk = ~clk;

   spart_tx_sched #(.DEPTH(DEPTH), .DIV_RESET(16'd325)) dut (
      .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .tx_data(tx_data),
      .tx_start(tx_start), .tx_en(tx_en),
`ifdef SPART_TX_IRQ_EN
      .irq(irq),
`endif
      .tx_tbr(tx_tbr));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Transmitter model and scoreboard: busy for busy_ticks baud ticks (at least 3 cycles) after each load
   initial begin
      tx_tbr = 1'b1;
      forever begin
         @(negedge clk);
         if (!rst && tx_start) begin
            n_starts++;
            chk("start_tbr_high", tx_tbr, 1);
            chk("start_after_rise", rose, 1);
            rose = 1'b0;
            chk("start_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("tx_data_order", tx_data, exp_q.pop_front());
            busy = 1'b1;
            busy_left = busy_ticks;
            busy_cyc = 0;
         end else if (busy) begin
            busy_cyc++;
            if (tx_en && busy_left > 0) busy_left--;
            if (busy_left == 0 && busy_cyc >= 3) busy = 1'b0;
         end
         if (!tx_tbr && !(busy || force_busy)) rose = 1'b1;
         tx_tbr = !(busy || force_busy);
      end
   end

   task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
      iocs = 1'b1; iorw = 1'b0; ioaddr = a; bus_wdata = d;
      @(negedge clk);
      iocs = 1'b0;
   endtask

   task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
      iocs = 1'b1; iorw = 1'b1; ioaddr = a;
      #1 d = bus_rdata;
      @(negedge clk);
      iocs = 1'b0; iorw = 1'b0;
   endtask

   task automatic wait_drain(input int bound);
      int c;
      logic [7:0] s;
      c = 0;
      while ((exp_q.size() != 0 || busy || !tx_tbr) && c < bound) begin
         @(negedge clk);
         c++;
      end
      chk("drain_in_time", c < bound, 1);
      repeat (4) @(negedge clk);
      bus_rd(2'b01, s);
      chk("status_drained", s, 8'h01);
   endtask

   initial begin
      logic [7:0] s, d;
      int last, np, first, s0, fill, c;
      bit ovr_m;
      rst = 1'b1; iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00; bus_wdata = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_tx_start", tx_start, 0);
      chk("rst_tx_en", tx_en, 0);
      chk("rst_tx_data", tx_data, 8'h00);
      chk("rst_rdata_idle", bus_rdata, 8'h00);
`ifdef SPART_TX_IRQ_EN
      chk("rst_irq", irq, 0);
`endif
      bus_rd(2'b01, s); chk("rst_status", s, 8'h01);
      bus_rd(2'b10, s); chk("rst_div_lo", s, 8'h45);
      bus_rd(2'b11, s); chk("rst_div_hi", s, 8'h01);
      bus_rd(2'b00, s); chk("rd_addr0", s, 8'h00);

      // divisor 3: first tick after 'div' cycles, then every div+1
      bus_wr(2'b11, 8'h00);
      bus_wr(2'b10, 8'h03);
      last = -1; np = 0; first = -1;
      for (int i = 0; i < 41; i++) begin
         @(negedge clk);
         if (tx_en) begin
            if (last >= 0) chk("tick_period", i - last, 4);
            else first = i;
            last = i;
            np++;
         end
      end
      chk("tick_first", first, 3);
      chk("tick_count", np, 10);
      bus_rd(2'b10, s); chk("div_lo_rb", s, 8'h03);
      bus_rd(2'b11, s); chk("div_hi_rb", s, 8'h00);
      bus_wr(2'b10, 8'h00);
      np = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (tx_en) np++;
      end
      chk("halt_ticks", np, 0);
      bus_wr(2'b10, 8'h03);

      // single byte latency: write edge N, pop N+1, strobe in the following cycle
      busy_ticks = 2;
      s0 = n_starts;
      exp_q.push_back(8'hA5);
      bus_wr(2'b00, 8'hA5);
      chk("lat_before", tx_start, 0);
      @(negedge clk);
      chk("lat_start", tx_start, 1);
      chk("lat_data", tx_data, 8'hA5);
      @(negedge clk);
      chk("lat_one_cycle", tx_start, 0);
      wait_drain(200);
      chk("lat_one_start", n_starts - s0, 1);

      // overflow with transmitter held busy
      force_busy = 1'b1;
      repeat (2) @(negedge clk);
      fill = 0; ovr_m = 1'b0;
      for (int i = 0; i < DEPTH + 1; i++) begin
         d = 8'($urandom);
         bus_wr(2'b00, d);
         if (fill < DEPTH) begin
            exp_q.push_back(d);
            fill++;
         end else ovr_m = 1'b1;
      end
      bus_rd(2'b01, s);
      chk("ovr_status", s, {5'b0, ovr_m, fill == DEPTH, 1'b0});
      bus_rd(2'b01, s);
      chk("ovr_cleared", s, {5'b0, 1'b0, fill == DEPTH, 1'b0});
      // release the transmitter so a push lands on the same edge as a pop from the full FIFO
      @(posedge clk);
      #1 force_busy = 1'b0;
      @(negedge clk);
      d = 8'($urandom);
      exp_q.push_back(d);
      bus_wr(2'b00, d);
      wait_drain(500);

      // randomized bursts with random transmitter busy time
      for (int r = 0; r < 4; r++) begin
         busy_ticks = $urandom_range(1, 4);
         np = $urandom_range(1, DEPTH);
         for (int i = 0; i < np; i++) begin
            d = 8'($urandom);
            exp_q.push_back(d);
            bus_wr(2'b00, d);
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         wait_drain(2000);
      end

      // long frames: 160 baud ticks per byte
      busy_ticks = 160;
      for (int i = 0; i < 3; i++) begin
         d = 8'($urandom);
         exp_q.push_back(d);
         bus_wr(2'b00, d);
      end
      wait_drain(3000);

      // reset during WAIT_DONE with two bytes queued
      busy_ticks = 20;
      s0 = n_starts;
      for (int i = 0; i < 3; i++) begin
         d = 8'($urandom);
         exp_q.push_back(d);
         bus_wr(2'b00, d);
      end
      c = 0;
      while (n_starts == s0 && c < 50) begin
         @(negedge clk);
         c++;
      end
      chk("rst_first_start", c < 50, 1);
      repeat (6) @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      s0 = n_starts;
      bus_wr(2'b11, 8'h00);
      bus_wr(2'b10, 8'h03);
      bus_rd(2'b01, s);
      chk("rst_mid_status_busy", s, {7'b0, tx_tbr});
      c = 0;
      while (!tx_tbr && c < 400) begin
         @(negedge clk);
         c++;
      end
      chk("rst_tbr_back", c < 400, 1);
      repeat (10) @(negedge clk);
      chk("rst_no_start", n_starts, s0);
      bus_rd(2'b01, s);
      chk("rst_mid_status", s, 8'h01);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
